// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag bit positions and FSM state encoding shared by the seq_alu slice
package alu_pkg;
    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_ILL  = 4'b1111;
    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response handshake bundle between decoder, seq_alu and writeback
interface seq_alu_if #(parameter int WIDTH = 8) ();
    logic             in_valid, in_ready, out_valid, out_ready, err_illegal;
    logic [3:0]       opcode, flags;
    logic [WIDTH-1:0] operand_a, operand_b, result, result_hi;
    modport master (
        output in_valid, opcode, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, result_hi, flags, err_illegal
    );
    modport slave (
        input  in_valid, opcode, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, result_hi, flags, err_illegal
    );
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
module seq_muldiv #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, s_hi, s_lo, s_b;
    logic             div_q, div_d, done_q, done_d, s_div, ge;
    logic [WIDTH:0]   sum, sh;
    // the start edge already performs the first iteration on the fresh operands
    always_comb begin
        s_hi = start ? '0 : hi_q;
        s_lo = start ? a : lo_q;
        s_b = start ? b : b_q;
        s_div = start ? is_div : div_q;
        sum = s_lo[0] ? {1'b0, s_hi} + {1'b0, s_b} : {1'b0, s_hi};
        sh = {s_hi, s_lo[WIDTH-1]};
        ge = sh >= {1'b0, s_b};
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        b_d = s_b;
        div_d = s_div;
        done_d = cnt_q == CNT_W'(1);
        if (start || cnt_q != '0) begin
            cnt_d = start ? CNT_W'(WIDTH - 1) : cnt_q - CNT_W'(1);
            hi_d = s_div ? (ge ? sh[WIDTH-1:0] - s_b : sh[WIDTH-1:0]) : sum[WIDTH:1];
            lo_d = s_div ? {s_lo[WIDTH-2:0], ge} : {sum[0], s_lo[WIDTH-1:1]};
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            b_q <= '0;
            div_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q <= b_d;
            div_q <= div_d;
            done_q <= done_d;
        end
    assign busy = cnt_q != '0 || done_q;
    assign done = done_q;
    assign lo = lo_q;
    assign hi = hi_q;
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; single-cycle ops finish on accept, mul/div run through seq_muldiv
module seq_alu
    import alu_pkg::*;
#(parameter int WIDTH = 8) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int M = WIDTH - 1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d, div_q, div_d, bz_q, bz_d;
    logic             accept, is_md, md_busy, md_done, c, v;
    logic [WIDTH-1:0] md_lo, md_hi, y, r;
    logic [WIDTH:0]   add_x, sub_x;
    assign is_md = bus.opcode == OP_MUL || bus.opcode == OP_DIV;
    assign accept = bus.in_valid && state_q == IDLE && !md_busy;
    seq_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk(clk), .rst(rst), .start(accept && is_md), .is_div(bus.opcode == OP_DIV),
        .a(bus.operand_a), .b(bus.operand_b), .busy(md_busy), .done(md_done),
        .lo(md_lo), .hi(md_hi)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            result_q <= '0;
            result_hi_q <= '0;
            flags_q <= '0;
            err_q <= 1'b0;
            div_q <= 1'b0;
            bz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            result_q <= result_d;
            result_hi_q <= result_hi_d;
            flags_q <= flags_d;
            err_q <= err_d;
            div_q <= div_d;
            bz_q <= bz_d;
        end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = accept ? (is_md ? BUSY : DONE) : IDLE;
            BUSY: state_d = md_done ? DONE : BUSY;
            default: state_d = bus.out_ready ? IDLE : DONE;
        endcase
    end
    // inc/dec reuse the add/sub paths with a constant one as second operand
    always_comb begin
        y = (bus.opcode == OP_INC || bus.opcode == OP_DEC) ? WIDTH'(1) : bus.operand_b;
        add_x = {1'b0, bus.operand_a} + {1'b0, y};
        sub_x = {1'b0, bus.operand_a} - {1'b0, y};
        r = bus.operand_a;
        c = 1'b0;
        v = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_INC: begin
                r = add_x[M:0];
                c = add_x[WIDTH];
                v = bus.operand_a[M] == y[M] && r[M] != bus.operand_a[M];
            end
            OP_SUB, OP_DEC: begin
                r = sub_x[M:0];
                c = sub_x[WIDTH];
                v = bus.operand_a[M] != y[M] && r[M] != bus.operand_a[M];
            end
            OP_AND: r = bus.operand_a & bus.operand_b;
            OP_OR: r = bus.operand_a | bus.operand_b;
            OP_NOT: r = ~bus.operand_a;
            OP_XOR: r = bus.operand_a ^ bus.operand_b;
            OP_ILL: r = '0;
            default: ;
        endcase
        result_d = result_q;
        result_hi_d = result_hi_q;
        flags_d = flags_q;
        err_d = err_q;
        div_d = accept ? bus.opcode == OP_DIV : div_q;
        bz_d = accept ? bus.operand_b == '0 : bz_q;
        if (accept && !is_md) begin
            result_d = r;
            result_hi_d = '0;
            err_d = bus.opcode == OP_ILL;
            flags_d[FLG_N] = r[M];
            flags_d[FLG_Z] = r == '0;
            flags_d[FLG_C] = c;
            flags_d[FLG_V] = v;
        end else if (state_q == BUSY && md_done) begin
            result_d = md_lo;
            result_hi_d = md_hi;
            err_d = 1'b0;
            flags_d[FLG_N] = md_lo[M];
            flags_d[FLG_Z] = div_q ? md_lo == '0 : {md_hi, md_lo} == '0;
            flags_d[FLG_C] = !div_q && md_hi != '0;
            flags_d[FLG_V] = div_q && bz_q;
        end
    end
    always_comb begin
        bus.in_ready = state_q == IDLE && !md_busy;
        bus.out_valid = state_q == DONE;
        bus.result = result_q;
        bus.result_hi = result_hi_q;
        bus.flags = flags_q;
        bus.err_illegal = err_q;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed table, handshake/reset sequences and random ops against an arithmetic model
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    seq_alu_if #(.WIDTH(8)) bus ();
    seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, r, hi;
        logic [3:0] f;
        logic       e;
        int         lat;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [7:0] hi,
                                  output logic [3:0] f, output logic e);
        int ia, ib, sa, sb, x, p;
        logic c, v, z;
        ia = a; ib = b; sa = $signed(a); sb = $signed(b);
        hi = 8'h00; c = 1'b0; v = 1'b0; e = 1'b0; p = ia * ib;
        case (op)
            4'h1: begin x = ia + ib; c = x > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            4'h2: begin x = ia - ib; c = ia < ib; v = (sa - sb > 127) || (sa - sb < -128); end
            4'h3: begin x = p % 256; hi = 8'(p / 256); c = hi != 0; end
            4'h4: if (ib == 0) begin x = 255; hi = a; v = 1'b1; end
                  else begin x = ia / ib; hi = 8'(ia % ib); end
            4'h5: begin x = ia + 1; c = x > 255; v = sa == 127; end
            4'h6: begin x = ia - 1; c = ia == 0; v = sa == -128; end
            4'h7: x = ia & ib;
            4'h8: x = ia | ib;
            4'h9: x = 255 - ia;
            4'hA: x = ia ^ ib;
            4'hF: begin x = 0; e = 1'b1; end
            default: x = ia;
        endcase
        r = 8'(x);
        z = (op == 4'h3) ? p == 0 : r == 0;
        f = {r[7], z, c, v};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [7:0] hi,
                          output logic [3:0] f, output logic e, output int lat);
        int g = 0;
        while (!bus.in_ready && g < 40) begin @(posedge clk); #1; g++; end
        chk("in_ready_before_issue", bus.in_ready, 1);
        bus.opcode = op; bus.operand_a = a; bus.operand_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.opcode = ~op; bus.operand_a = ~a; bus.operand_b = ~b;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        r = bus.result; hi = bus.result_hi; f = bus.flags; e = bus.err_illegal;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] r, hi, er, ehi, a, b;
        logic [3:0] f, ef, op;
        logic e, ee, seen;
        int lat;
        tbl[0]  = '{4'h1, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0110, 1'b0, 1};
        tbl[1]  = '{4'h2, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 1'b0, 1};
        tbl[2]  = '{4'h6, 8'h00, 8'h55, 8'hFF, 8'h00, 4'b1010, 1'b0, 1};
        tbl[3]  = '{4'h3, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010, 1'b0, 9};
        tbl[4]  = '{4'h4, 8'd200, 8'd7, 8'd28, 8'd4, 4'b0000, 1'b0, 9};
        tbl[5]  = '{4'h4, 8'd200, 8'd0, 8'hFF, 8'hC8, 4'b1001, 1'b0, 9};
        tbl[6]  = '{4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0100, 1'b1, 1};
        tbl[7]  = '{4'h5, 8'h7F, 8'h00, 8'h80, 8'h00, 4'b1001, 1'b0, 1};
        tbl[8]  = '{4'h5, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0110, 1'b0, 1};
        tbl[9]  = '{4'h7, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1'b0, 1};
        tbl[10] = '{4'h8, 8'h80, 8'h01, 8'h81, 8'h00, 4'b1000, 1'b0, 1};
        tbl[11] = '{4'h9, 8'h0F, 8'h00, 8'hF0, 8'h00, 4'b1000, 1'b0, 1};
        tbl[12] = '{4'hA, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0100, 1'b0, 1};
        tbl[13] = '{4'h0, 8'h00, 8'h77, 8'h00, 8'h00, 4'b0100, 1'b0, 1};
        tbl[14] = '{4'hD, 8'h9C, 8'h11, 8'h9C, 8'h00, 4'b1000, 1'b0, 1};
        tbl[15] = '{4'h3, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0100, 1'b0, 9};
        tbl[16] = '{4'h3, 8'h10, 8'h10, 8'h00, 8'h01, 4'b0010, 1'b0, 9};
        tbl[17] = '{4'h1, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1001, 1'b0, 1};
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.opcode = 4'h0;
        bus.operand_a = 8'h00; bus.operand_b = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_result_hi", bus.result_hi, 0);
        chk("reset_flags", bus.flags, 0);
        chk("reset_err", bus.err_illegal, 0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, hi, f, e, lat);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_result_hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d_flags", i), f, tbl[i].f);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
        end

        // stalled consumer: outputs frozen, no new request taken
        bus.out_ready = 1'b0;
        bus.opcode = 4'hF; bus.operand_a = 8'h5A; bus.operand_b = 8'hA5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("stall_out_valid", bus.out_valid, 1);
        bus.opcode = 4'h1; bus.operand_a = 8'h01; bus.operand_b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_hold_out_valid", bus.out_valid, 1);
            chk("stall_hold_in_ready", bus.in_ready, 0);
            chk("stall_hold_result", bus.result, 0);
            chk("stall_hold_flags", bus.flags, 4'b0100);
            chk("stall_hold_err", bus.err_illegal, 1);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_out_valid", bus.out_valid, 0);
        chk("stall_release_in_ready", bus.in_ready, 1);

        run_op(4'h3, 8'hFF, 8'hFF, r, hi, f, e, lat);
        chk("pre_reset_mul_result", r, 8'h01);

        // reset during the fourth BUSY cycle discards the partial product
        bus.opcode = 4'h3; bus.operand_a = 8'hFF; bus.operand_b = 8'hFF; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midop_reset_in_ready", bus.in_ready, 1);
        chk("midop_reset_out_valid", bus.out_valid, 0);
        chk("midop_reset_result", bus.result, 0);
        chk("midop_reset_result_hi", bus.result_hi, 0);
        chk("midop_reset_flags", bus.flags, 0);
        chk("midop_reset_err", bus.err_illegal, 0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; seen |= bus.out_valid; end
        chk("midop_reset_no_stale_result", seen, 0);
        run_op(4'h1, 8'd3, 8'd4, r, hi, f, e, lat);
        chk("post_reset_add_result", r, 8'd7);
        chk("post_reset_add_flags", f, 4'b0000);
        chk("post_reset_add_latency", lat, 1);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(op, a, b, er, ehi, ef, ee);
            run_op(op, a, b, r, hi, f, e, lat);
            chk($sformatf("rnd%0d_op%0h_result", i, op), r, er);
            chk($sformatf("rnd%0d_op%0h_result_hi", i, op), hi, ehi);
            chk($sformatf("rnd%0d_op%0h_flags", i, op), f, ef);
            chk($sformatf("rnd%0d_op%0h_err", i, op), e, ee);
            chk($sformatf("rnd%0d_op%0h_latency", i, op), lat, (op == 4'h3 || op == 4'h4) ? 9 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU.
- Implements the full 4-bit opcode map, including the previously reserved multiply (0011) and divide (0100), as multi-cycle iterative operations.
- Produces a status-flag vector and defines a behaviour for every opcode.
- Sits between the register file/decoder and the writeback path; valid/ready on both sides lets the control unit stall on multi-cycle ops.

Parameters:
- WIDTH, 8: operand/result width in bits, must be >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- opcode  input  4  operation select.
- operand_a  input  WIDTH  first operand.
- operand_b  input  WIDTH  second operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  primary result (sum, low product, quotient, ...).
- result_hi  output  WIDTH  high product / remainder; 0 for other ops.
- flags  output  4  {N,Z,C,V}.
- err_illegal  output  1  opcode 1111 was issued; valid with out_valid.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, any state, mid-op included) -> IDLE. Every output reg clears to 0 and in_ready=1; any partial mul/div is discarded.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready at a rising edge. Operands and opcode are captured; later input changes are ignored.
- Single-cycle ops (all except 0011/0100): IDLE -> DONE, with out_valid=1 on the cycle after accept.
- Mul/div: IDLE -> BUSY for WIDTH cycles, then DONE. out_valid asserts WIDTH+1 cycles after accept.
- DONE holds result, result_hi, flags and err_illegal stable until out_valid & out_ready, then returns to IDLE. If out_ready is already high, the earliest next accept is one cycle after the handshake, giving max throughput of 1 op per 2 cycles.
- Opcode map (A=operand_a, B=operand_b, all modulo 2^WIDTH):
  - 0000 A
  - 0001 A+B
  - 0010 A-B
  - 0011 A*B unsigned; low half in result, high half in result_hi
  - 0100 A/B unsigned; quotient in result, remainder in result_hi
  - 0101 A+1
  - 0110 A-1
  - 0111 A&B
  - 1000 A|B
  - 1001 ~A
  - 1010 A^B
  - 1011-1110 A
  - 1111: result=0, err_illegal=1, flags=0100
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0); for mul, Z requires the full 2*WIDTH product to be zero.
  - C: add/inc carry-out; sub/dec borrow (unsigned A<B, or A==0 for dec); mul = (result_hi!=0); all other ops 0.
  - V: add/sub/inc/dec signed overflow; div = divide-by-zero; all other ops 0.
- Multiply: shift-add, one partial product per BUSY cycle.
- Divide: restoring, one quotient bit per cycle.
- Divide by zero: quotient = all ones, remainder = A, V=1, C=0. Takes the same WIDTH+1 latency; no early exit.
- in_valid while not in IDLE: the request is not accepted and the requester must hold it.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_PASS..OP_ILL (4'b0000..4'b1111);
  - flag bit indices FLG_V=0, FLG_C=1, FLG_Z=2, FLG_N=3;
  - the state encoding IDLE/BUSY/DONE.
- Sub-module seq_muldiv (parameter WIDTH):
  - ports: start, is_div, A, B, busy, done pulse, lo, hi;
  - contains the iteration counter and the shift/accumulate datapath.
- seq_alu keeps the handshake FSM, single-cycle datapath and flag logic.

Test Plan:
- WIDTH=8, op 0001, A=8'hFF, B=8'h01, out_ready=1 -> out_valid 1 cycle after accept, result=00, flags N0 Z1 C1 V0.
- op 0010, A=8'h80, B=8'h01 -> result=7F, flags N0 Z0 C0 V1. Then op 0110 with A=00 -> result=FF, N1 C1 V0.
- op 0011, A=8'hFF, B=8'hFF -> out_valid exactly 9 cycles after accept, result=01, result_hi=FE, C=1, Z=0.
- op 0100, A=8'd200, B=8'd7 -> result=8'd28, result_hi=8'd4, 9-cycle latency. Repeat with B=0 -> result=FF, result_hi=C8, V=1.
- op 1111 -> result=0, err_illegal=1, flags=0100. Also hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout, new in_valid not accepted.
- Start op 0011; assert rst during cycle 4 of BUSY -> immediate in_ready=1, out_valid=0, all outputs 0. Next op 0001, 3+4 -> result=7 with normal latency.
